// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: one request at a time, byte-strobed SRAM, fixed wait states
// Outputs are registered; a load accepted in the RESP cycle of a store sees the stored bytes via forwarding.
module dmem_responder #(
  parameter logic [31:0] BASE    = 32'h0000_0000,
  parameter int          DEPTH   = 4096,
  parameter int          LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_fence,
  input  logic        mem_spec,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_error
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
  localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        fence_q, fence_d;
  logic        hit_q, hit_d;
  logic        ready_q, ready_d;
  logic        error_q, error_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rd_word;

  logic [31:0] mem_array [DEPTH];

  logic [31:0]   in_off, q_off, d_off;
  logic          in_hit;
  logic [AW-1:0] wr_idx, rd_idx;
  logic          do_write;
  logic          unused_bits;

  assign in_off   = mem_addr - BASE;
  assign in_hit   = {1'b0, in_off} < SPAN;
  assign q_off    = addr_q - BASE;
  assign d_off    = addr_d - BASE;
  assign wr_idx   = q_off[AW+1:2];
  assign rd_idx   = d_off[AW+1:2];
  assign do_write = (state_q == S_RESP) && !fence_q && hit_q && (wstrb_q != 4'd0);

  assign unused_bits = ^{mem_spec, mem_instr, q_off[31:AW+2], q_off[1:0],
                         d_off[31:AW+2], d_off[1:0]};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      fence_q <= 1'b0;
      hit_q   <= 1'b0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      fence_q <= fence_d;
      hit_q   <= hit_d;
      ready_q <= ready_d;
      error_q <= error_d;
      rdata_q <= rdata_d;
    end
  end

  // Reset gates the write so a store caught by reset in its RESP cycle is dropped.
  always_ff @(posedge clock) begin
    if (reset && do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem_array[wr_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    fence_d = fence_q;
    hit_d   = hit_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (mem_valid) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          fence_d = mem_fence;
          hit_d   = in_hit;
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Response is computed for the request that will sit in RESP next cycle.
  always_comb begin
    ready_d = (state_d == S_RESP);
    error_d = ready_d && !fence_d && !hit_d;
    rd_word = mem_array[rd_idx];
    if (do_write && (wr_idx == rd_idx)) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) rd_word[8*i +: 8] = wdata_q[8*i +: 8];
      end
    end
    rdata_d = (ready_d && !fence_d && hit_d && (wstrb_d == 4'd0)) ? rd_word : 32'd0;
  end

  assign mem_ready = ready_q;
  assign mem_error = error_q;
  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder at latencies 1, 3 and 4
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  logic        fence = 1'b0;
  logic        valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
  logic        rdy_a, rdy_b, rdy_c, err_a, err_b, err_c;
  logic [31:0] rd_a, rd_b, rd_c;
  int          n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  dmem_responder #(.BASE(32'h0), .DEPTH(16), .LATENCY(1)) dut_a (
    .clock(clk), .reset(rst_n), .mem_valid(valid_a), .mem_fence(fence), .mem_spec(1'b0),
    .mem_instr(1'b0), .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb),
    .mem_ready(rdy_a), .mem_rdata(rd_a), .mem_error(err_a));

  dmem_responder #(.BASE(32'h1000), .DEPTH(16), .LATENCY(3)) dut_b (
    .clock(clk), .reset(rst_n), .mem_valid(valid_b), .mem_fence(fence), .mem_spec(1'b0),
    .mem_instr(1'b0), .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb),
    .mem_ready(rdy_b), .mem_rdata(rd_b), .mem_error(err_b));

  dmem_responder #(.BASE(32'h0), .DEPTH(16), .LATENCY(4)) dut_c (
    .clock(clk), .reset(rst_n), .mem_valid(valid_c), .mem_fence(fence), .mem_spec(1'b0),
    .mem_instr(1'b0), .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb),
    .mem_ready(rdy_c), .mem_rdata(rd_c), .mem_error(err_c));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        fence;
    logic [31:0] exp_rdata;
    logic        exp_error;
  } vec_t;

  vec_t va[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sample(input int which, output logic r, output logic [31:0] d, output logic e);
    case (which)
      0:       begin r = rdy_a; d = rd_a; e = err_a; end
      1:       begin r = rdy_b; d = rd_b; e = err_b; end
      default: begin r = rdy_c; d = rd_c; e = err_c; end
    endcase
  endtask

  task automatic set_valid(input int which, input logic v);
    valid_a = (which == 0) ? v : 1'b0;
    valid_b = (which == 1) ? v : 1'b0;
    valid_c = (which == 2) ? v : 1'b0;
  endtask

  task automatic drive(input int which, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic f);
    addr = a; wdata = d; wstrb = s; fence = f;
    set_valid(which, 1'b1);
  endtask

  task automatic release_req();
    set_valid(0, 1'b0);
    valid_a = 1'b0;
    wstrb = 4'd0; fence = 1'b0;
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic txn(input int which, input string name, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s, input logic f,
                     input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    logic r, e;
    logic [31:0] q;
    lat = (which == 0) ? 1 : (which == 1) ? 3 : 4;
    drive(which, a, d, s, f);
    @(posedge clk); #1;
    release_req();
    for (int k = 1; k <= lat; k++) begin
      sample(which, r, q, e);
      if (k < lat) begin
        chk({name, " early ready"}, {31'd0, r}, 32'd0);
        chk({name, " early error"}, {31'd0, e}, 32'd0);
        chk({name, " early rdata"}, q, 32'd0);
        @(posedge clk); #1;
      end else begin
        chk({name, " ready"}, {31'd0, r}, 32'd1);
        chk({name, " rdata"}, q, exp_rd);
        chk({name, " error"}, {31'd0, e}, {31'd0, exp_err});
      end
    end
    @(posedge clk); #1;
    sample(which, r, q, e);
    chk({name, " ready pulse end"}, {31'd0, r}, 32'd0);
    chk({name, " rdata after"}, q, 32'd0);
    chk({name, " error after"}, {31'd0, e}, 32'd0);
  endtask

  initial begin
    logic r, e;
    logic [31:0] q;

    va[0]  = '{32'h10, 32'hDEADBEEF, 4'hF,    1'b0, 32'h0,        1'b0};
    va[1]  = '{32'h10, 32'h0,        4'h0,    1'b0, 32'hDEADBEEF, 1'b0};
    va[2]  = '{32'h10, 32'h0000AA00, 4'b0010, 1'b0, 32'h0,        1'b0};
    va[3]  = '{32'h10, 32'h0,        4'h0,    1'b0, 32'hDEADAAEF, 1'b0};
    va[4]  = '{32'h3C, 32'h11223344, 4'hF,    1'b0, 32'h0,        1'b0};
    va[5]  = '{32'h3C, 32'h0,        4'h0,    1'b0, 32'h11223344, 1'b0};
    va[6]  = '{32'h00, 32'h12345678, 4'hF,    1'b0, 32'h0,        1'b0};
    va[7]  = '{32'h40, 32'h0,        4'h0,    1'b0, 32'h0,        1'b1};
    va[8]  = '{32'h40, 32'hCAFEF00D, 4'hF,    1'b0, 32'h0,        1'b1};
    va[9]  = '{32'h00, 32'h0,        4'h0,    1'b0, 32'h12345678, 1'b0};
    va[10] = '{32'h10, 32'hFFFFFFFF, 4'hF,    1'b1, 32'h0,        1'b0};
    va[11] = '{32'h13, 32'h0,        4'h0,    1'b0, 32'hDEADAAEF, 1'b0};
    va[12] = '{32'h3C, 32'hA10000B2, 4'b1001, 1'b0, 32'h0,        1'b0};
    va[13] = '{32'h3C, 32'h0,        4'h0,    1'b0, 32'hA12233B2, 1'b0};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int w = 0; w < 3; w++) begin
      sample(w, r, q, e);
      chk($sformatf("reset ready %0d", w), {31'd0, r}, 32'd0);
      chk($sformatf("reset rdata %0d", w), q, 32'd0);
      chk($sformatf("reset error %0d", w), {31'd0, e}, 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      txn(0, $sformatf("lat1 vec%0d", i), va[i].addr, va[i].wdata, va[i].wstrb,
          va[i].fence, va[i].exp_rdata, va[i].exp_error);
    end
    txn(0, "lat1 wrap miss", 32'hFFFFFFFC, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1);

    // Read-after-write: load accepted in the store's RESP cycle.
    drive(0, 32'h20, 32'h55AA55AA, 4'hF, 1'b0);
    @(posedge clk); #1;
    chk("raw store ready", {31'd0, rdy_a}, 32'd1);
    drive(0, 32'h20, 32'h0, 4'h0, 1'b0);
    @(posedge clk); #1;
    release_req();
    chk("raw load ready", {31'd0, rdy_a}, 32'd1);
    chk("raw load rdata", rd_a, 32'h55AA55AA);
    @(posedge clk); #1;
    chk("raw ready end", {31'd0, rdy_a}, 32'd0);

    txn(1, "lat3 store", 32'h1004, 32'h0BADCAFE, 4'hF, 1'b0, 32'h0, 1'b0);
    txn(1, "lat3 store2", 32'h1008, 32'h00000077, 4'hF, 1'b0, 32'h0, 1'b0);
    txn(1, "lat3 load", 32'h1004, 32'h0, 4'h0, 1'b0, 32'h0BADCAFE, 1'b0);
    txn(1, "lat3 below base", 32'h0FFC, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1);
    txn(1, "lat3 past end", 32'h1040, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1);
    txn(1, "lat3 last word", 32'h103C, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0);

    // Back-to-back at latency 3: second load issued in the first one's RESP cycle.
    drive(1, 32'h1004, 32'h0, 4'h0, 1'b0);
    @(posedge clk); #1;
    release_req();
    chk("b2b t+1 ready", {31'd0, rdy_b}, 32'd0);
    @(posedge clk); #1;
    chk("b2b t+2 ready", {31'd0, rdy_b}, 32'd0);
    @(posedge clk); #1;
    chk("b2b t+3 ready", {31'd0, rdy_b}, 32'd1);
    chk("b2b t+3 rdata", rd_b, 32'h0BADCAFE);
    drive(1, 32'h1008, 32'h0, 4'h0, 1'b0);
    @(posedge clk); #1;
    release_req();
    chk("b2b t+4 ready", {31'd0, rdy_b}, 32'd0);
    @(posedge clk); #1;
    chk("b2b t+5 ready", {31'd0, rdy_b}, 32'd0);
    @(posedge clk); #1;
    chk("b2b t+6 ready", {31'd0, rdy_b}, 32'd1);
    chk("b2b t+6 rdata", rd_b, 32'h00000077);
    @(posedge clk); #1;
    chk("b2b t+7 ready", {31'd0, rdy_b}, 32'd0);

    // Reset during the WAIT of a latency-4 store.
    txn(2, "lat4 store", 32'h8, 32'h13572468, 4'hF, 1'b0, 32'h0, 1'b0);
    drive(2, 32'h8, 32'hFFFFFFFF, 4'hF, 1'b0);
    @(posedge clk); #1;
    release_req();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midreset ready", {31'd0, rdy_c}, 32'd0);
    chk("midreset rdata", rd_c, 32'd0);
    chk("midreset error", {31'd0, err_c}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("midreset no ready %0d", k), {31'd0, rdy_c}, 32'd0);
    end
    txn(2, "lat4 reload", 32'h8, 32'h0, 4'h0, 1'b0, 32'h13572468, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder: the memory-side end of the `mem_in_type` request interface that the decode stage drives as `dmem_in`. It accepts one load, store or fence request at a time and applies byte-strobed writes to a local word-addressed SRAM array. After a programmable number of wait states it returns `mem_ready` with read data, or with an error flag for out-of-range addresses. It sits between the pipeline and the data TCM and provides the `mem_out_type` response consumed by the memory/writeback stage.

## Interface
Parameters:
- `BASE`, `32'h0000_0000`: byte base address of the array; must be aligned to 4*`DEPTH`.
- `DEPTH`, 4096: number of 32-bit words; must be a power of two, 2 or more.
- `LATENCY`, 1: cycles from request acceptance to `mem_ready`; legal range 1..15.

Ports:
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-low.
- `mem_valid`  in  1: request strobe, valid for one cycle.
- `mem_fence`  in  1: fence request (qualified by `mem_valid`).
- `mem_spec`  in  1: speculative hint; ignored, always 0 from the pipeline.
- `mem_instr`  in  1: instruction-fetch flag; ignored, always 0 on the data side.
- `mem_addr`  in  32: byte address; bits [1:0] ignored.
- `mem_wdata`  in  32: store data, already lane-aligned.
- `mem_wstrb`  in  4: byte enables; 0 = load, nonzero = store.
- `mem_ready`  out  1: response valid, one-cycle pulse.
- `mem_rdata`  out  32: load data; 0 whenever `mem_ready`=0.
- `mem_error`  out  1: access fault, valid with `mem_ready`.

## Operation
- State machine has three states: IDLE, WAIT, RESP.
- IDLE: when `mem_valid`=1, capture the request into the request register: address, wdata, wstrb, fence, and `hit`.
  - `hit` = (`mem_addr` - `BASE`) < 4*`DEPTH`, evaluated as an unsigned 32-bit compare.
  - If `LATENCY`=1, go to RESP; otherwise load the counter with `LATENCY`-2 and go to WAIT.
- WAIT: decrement the counter; go to RESP when it is 0.
- RESP, taken in order:
  - Fence: `mem_ready`=1, `mem_rdata`=0, `mem_error`=0, no array access.
  - Miss: `mem_ready`=1, `mem_error`=1, `mem_rdata`=0, no write.
  - Load hit: `mem_rdata` = array[(addr-`BASE`)[log2(DEPTH)+1:2]].
  - Store hit: write the lanes with wstrb[i]=1 (byte i = wdata[8i+7:8i]) on the RESP clock edge; `mem_rdata`=0.
  - A new `mem_valid` in RESP is accepted exactly as in IDLE (back-to-back); otherwise return to IDLE.
- `mem_valid` in WAIT is a protocol violation: the request is dropped and the verification bench flags it as an assertion. The pipeline stalls on `mem_ready`=0, so it never issues one.
- The array is read combinationally from the registered index, or uses a registered read launched in the last wait cycle; either way the data must be visible in RESP.
- The array is not initialised by reset.

## Timing
- Reset (`reset`=0 at a rising edge): state=IDLE, counter=0, request register cleared. `mem_ready`=0, `mem_rdata`=0, `mem_error`=0 from the next cycle.
- Reset mid-operation: the pending request is discarded with no response, and a pending store is not written. Array contents are retained.
- Latency: request at cycle t gives `mem_ready`=1 in cycle t+`LATENCY`, for exactly one cycle.
- Throughput: 1 request per `LATENCY` cycles; a request in the RESP cycle is accepted.
- Read-after-write: a store answered at cycle t followed by a load of the same word accepted at t gives the stored data at t+`LATENCY`.
- Outputs are registered and free of glitches. `mem_error`=0 whenever `mem_ready`=0.
- Address wrap: `mem_addr` below `BASE` underflows the subtraction, so the unsigned compare gives a miss. The last word (`BASE`+4*`DEPTH`-4) hits; `BASE`+4*`DEPTH` misses.
- `mem_fence` together with nonzero `mem_wstrb`: the fence takes priority and no write occurs.

## Test plan
- `LATENCY`=1, `BASE`=0:
  - store `32'hDEADBEEF` to `0x10` with wstrb `4'hF`, then load `0x10` -> `mem_ready` at t+1 for each, `mem_rdata`=`32'hDEADBEEF`.
  - store `32'h0000AA00` with wstrb `4'b0010` to `0x10` -> subsequent load returns `32'hDEADAAEF`.
- `LATENCY`=3: load at t -> `mem_ready` only at t+3, 0 at t+1 and t+2. A back-to-back load issued at t+3 -> ready at t+6.
- Addresses:
  - `DEPTH`=16: load `0x3C` -> hit.
  - load `0x40` -> `mem_ready`=1, `mem_error`=1, `mem_rdata`=0.
  - `BASE`=`0x1000`, load `0x0FFC` -> error.
  - store to `0x40` -> no array word modified.
- Fence with wstrb `4'hF` -> ready after `LATENCY`, rdata 0, error 0, array unchanged.
- Reset asserted during WAIT of a store (`LATENCY`=4) -> no `mem_ready` ever for it, outputs 0 next cycle, word unchanged on reload.
